life_matrix_scan: RTL and testbench
===================================

Name: life_matrix_scan

Overview:
Downstream consumer of the life-generation register. It accepts each 64-bit generation over a valid/ready handshake and double-buffers it. It multiplexes the frame row-by-row onto an 8x8 LED matrix and reports the live-cell population of the frame currently displayed. New generations are shown only at frame boundaries, so no row ever mixes two generations.

Parameters:
DWELL_CYCLES, 1000, clock cycles each row is driven (>=1)
BLANK_CYCLES, 16, all-off cycles between rows for ghost suppression (0 = no blanking)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
grid_in  input  64  generation to display; bit index r*8+c = row r, column c
grid_valid  input  1  grid_in holds a new generation
grid_ready  output  1  pending buffer empty; transfer occurs when grid_valid && grid_ready
row_sel  output  8  one-hot row drive, bit r = row r
col_data  output  8  column data for the driven row = display[r*8+7 : r*8]
frame_done  output  1  one-cycle pulse after the last row of a frame completes
population  output  7  live-cell count (0..64) of the displayed frame

Behaviour:
- Reset (reset=0, asynchronous):
  - pending and display buffers = 0; pending_full = 0, so grid_ready = 1.
  - row_sel = 0, col_data = 0, frame_done = 0, population = 0.
  - State = IDLE; row index = 0; dwell counter = 0.
- Reset asserted mid-scan aborts immediately. No partial frame resumes.
- All outputs are registered except grid_ready = ~pending_full.
- Handshake: transfer when grid_valid && grid_ready. grid_in latches into pending and pending_full sets. pending_full clears only on a swap. grid_valid while grid_ready = 0 is ignored; the source must hold the data.
- States:
  - IDLE: row_sel = 0, col_data = 0. If pending_full: swap (display <= pending, pending_full <= 0), row = 0, go to SCAN. From accept edge k, row 0 is visible after edge k+1.
  - SCAN: row_sel = 1<<row, col_data = current row slice, held exactly DWELL_CYCLES cycles.
    - Then, if BLANK_CYCLES > 0, go to BLANK; otherwise advance directly.
  - BLANK: row_sel = 0, col_data = 0 for exactly BLANK_CYCLES cycles, then advance.
  - Advance, row < 7: row+1, go to SCAN.
  - Advance, row == 7 (frame end): frame_done = 1 for one cycle.
    - If pending_full, swap.
    - Row wraps to 0 and the state returns to SCAN. The old frame repeats when nothing is pending.
- Simultaneous events:
  - Accept and swap cannot coincide, because ready is low while pending is full.
  - grid_valid in the frame-end cycle with pending empty: the grid is accepted into pending and displayed at the next frame end. There is no bypass.
- population: registered popcount of display, updated the cycle after each swap. Stable otherwise.
- Frame period = 8*(DWELL_CYCLES+BLANK_CYCLES) cycles. Dwell counter width = clog2 of the larger of the two parameters.

Optional Feature:
LIFE_MATRIX_SCAN_ACTIVE_LOW_EN
- Defined: row_sel and col_data are driven inverted, for common-anode matrices.
  - Reset, IDLE and BLANK values = 8'hFF.
  - frame_done, population and the handshake are unchanged.
- Undefined: active-high as specified above.

Decomposition:
- Package life_pkg:
  - GRID_N = 8, GRID_BITS = 64, POP_W = 7.
  - scan_state_t enum {IDLE, SCAN, BLANK}.
  - Function row_slice(grid, row) returning 8 bits.
- One sub-module: popcount64 (combinational 64-bit to 7-bit adder tree), feeding the population register.

Test Plan:
(All with DWELL_CYCLES=4, BLANK_CYCLES=1.)
- Reset then idle → grid_ready=1, row_sel=0, col_data=0, population=0 for 20 cycles with no grid_valid.
- Accept grid_in=64'h8000_0000_0000_0001 → row_sel=01/col_data=01 for 4 cycles, 1 blank cycle, then rows 02..40 with col_data=00, row 80 with col_data=80. frame_done pulses after row 7's blank. population=2.
- Second grid 64'hFFFF_FFFF_FFFF_FFFF offered mid-frame → grid_ready drops after the accept. The current frame completes unchanged. The next frame shows col_data=FF on all rows. population=64 one cycle after the swap. grid_ready returns to 1.
- Third grid offered while pending full → grid_valid held with no transfer until the frame-end swap empties pending. Accepted the cycle after the swap.
- No new grid across 3 frames → the same frame repeats. frame_done pulses every 40 cycles. population is constant.
- Assert reset during row 3 → outputs go to 0 asynchronously. After release the state is IDLE and the previous frame is not redisplayed until a new accept.

Source files
------------

// File: rtl/life_matrix_scan_pkg.sv
// Shared types and helpers for the life-generation LED matrix scanner.
package life_pkg;

  localparam int GRID_N    = 8;
  localparam int GRID_BITS = 64;
  localparam int POP_W     = 7;

  typedef enum logic [1:0] {IDLE, SCAN, BLANK} scan_state_t;

  function automatic logic [GRID_N-1:0] row_slice(input logic [GRID_BITS-1:0] grid,
                                                  input logic [2:0]           row);
    return grid[{row, 3'b000} +: GRID_N];
  endfunction

endpackage

// File: rtl/life_matrix_scan_popcount64.sv
// Combinational live-cell counter: per-row counts summed into a 7-bit total.
module popcount64
  import life_pkg::*;
(
  input  logic [GRID_BITS-1:0] data_i,
  output logic [POP_W-1:0]     count_o
);

  logic [3:0] rowCount [GRID_N];

  always_comb begin
    count_o = '0;
    for (int b = 0; b < GRID_N; b++) begin
      rowCount[b] = '0;
      for (int i = 0; i < GRID_N; i++) begin
        rowCount[b] = rowCount[b] + 4'(data_i[b*GRID_N+i]);
      end
      count_o = count_o + POP_W'(rowCount[b]);
    end
  end

endmodule

// File: rtl/life_matrix_scan.sv
// Double-buffered 8x8 row scanner with frame-aligned generation swaps and population report.
// Define LIFE_MATRIX_SCAN_ACTIVE_LOW_EN to drive row_sel/col_data inverted for common-anode matrices.
module life_matrix_scan
  import life_pkg::*;
#(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [GRID_BITS-1:0] grid_in,
  input  logic                 grid_valid,
  output logic                 grid_ready,
  output logic [GRID_N-1:0]    row_sel,
  output logic [GRID_N-1:0]    col_data,
  output logic                 frame_done,
  output logic [POP_W-1:0]     population
);

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

`ifdef LIFE_MATRIX_SCAN_ACTIVE_LOW_EN
  localparam logic [GRID_N-1:0] DRIVE_XOR = 8'hFF;
`else
  localparam logic [GRID_N-1:0] DRIVE_XOR = 8'h00;
`endif

  scan_state_t          state_q;
  logic [2:0]           row_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [GRID_BITS-1:0] display_q, pending_q, pending_d;
  logic                 pendingFull_q, pendingFull_d;
  logic [GRID_N-1:0]    rowSel_q, colData_q;
  logic                 frameDone_q;
  logic [POP_W-1:0]     population_q, popCount;

  logic                 rowDone, blankDone, advance, frameEnd, startSwap, swap;
  logic [2:0]           nextRow;
  logic [GRID_BITS-1:0] nextGrid;

  always_comb begin
    rowDone   = (state_q == SCAN) && (cnt_q == DWELL_LAST);
    blankDone = (state_q == BLANK) && (cnt_q == BLANK_LAST);
    advance   = blankDone || (rowDone && (BLANK_CYCLES == 0));
    frameEnd  = advance && (row_q == 3'd7);
    startSwap = (state_q == IDLE) && pendingFull_q;
    swap      = startSwap || (frameEnd && pendingFull_q);
    nextRow   = row_q + 3'd1;
    nextGrid  = (frameEnd && pendingFull_q) ? pending_q : display_q;
  end

  // Pending slot only refills while empty, so an accept never lands on a swap edge.
  always_comb begin
    pending_d     = pending_q;
    pendingFull_d = pendingFull_q;
    if (swap) begin
      pendingFull_d = 1'b0;
    end else if (grid_valid && !pendingFull_q) begin
      pending_d     = grid_in;
      pendingFull_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q     <= '0;
      pendingFull_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      pendingFull_q <= pendingFull_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      cnt_q       <= '0;
      display_q   <= '0;
      rowSel_q    <= DRIVE_XOR;
      colData_q   <= DRIVE_XOR;
      frameDone_q <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      if (advance) begin
        cnt_q     <= '0;
        row_q     <= nextRow;
        state_q   <= SCAN;
        rowSel_q  <= (8'd1 << nextRow) ^ DRIVE_XOR;
        colData_q <= row_slice(nextGrid, nextRow) ^ DRIVE_XOR;
        if (frameEnd) begin
          frameDone_q <= 1'b1;
          if (pendingFull_q) display_q <= pending_q;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (startSwap) begin
              display_q <= pending_q;
              row_q     <= '0;
              cnt_q     <= '0;
              state_q   <= SCAN;
              rowSel_q  <= 8'd1 ^ DRIVE_XOR;
              colData_q <= row_slice(pending_q, 3'd0) ^ DRIVE_XOR;
            end
          end
          SCAN: begin
            if (rowDone) begin
              cnt_q     <= '0;
              state_q   <= BLANK;
              rowSel_q  <= DRIVE_XOR;
              colData_q <= DRIVE_XOR;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          BLANK:   cnt_q <= cnt_q + CNT_W'(1);
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  popcount64 uPopcount (
    .data_i  (display_q),
    .count_o (popCount)
  );

  // Tracks display one cycle late, so it settles the cycle after each swap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) population_q <= '0;
    else        population_q <= popCount;
  end

  assign grid_ready = ~pendingFull_q;
  assign row_sel    = rowSel_q;
  assign col_data   = colData_q;
  assign frame_done = frameDone_q;
  assign population = population_q;

endmodule

// File: tb/tb_life_matrix_scan.sv
// Randomized self-checking bench for life_matrix_scan against a frame-timeline reference model.
module tb_life_matrix_scan;

  localparam int DWELL = 4;
  localparam int BLANK = 1;
  localparam int ROWT  = DWELL + BLANK;
  localparam int FRAME = 8 * ROWT;

`ifdef LIFE_MATRIX_SCAN_ACTIVE_LOW_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        grid_valid = 1'b0;
  logic [63:0] grid_in = '0;
  logic        grid_ready;
  logic [7:0]  row_sel, col_data;
  logic        frame_done;
  logic [6:0]  population;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: scan position is plain elapsed time since the first swap.
  bit          mScanning;
  int          mT;
  logic [63:0] mDisplay, mPending;
  bit          mPendFull;
  int          mPop;
  bit          mFrameDone;
  bit          lastAccept;

  life_matrix_scan #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
    .clk        (clk),
    .reset      (reset),
    .grid_in    (grid_in),
    .grid_valid (grid_valid),
    .grid_ready (grid_ready),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_done (frame_done),
    .population (population)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mScanning  = 1'b0;
    mT         = 0;
    mDisplay   = '0;
    mPending   = '0;
    mPendFull  = 1'b0;
    mPop       = 0;
    mFrameDone = 1'b0;
    lastAccept = 1'b0;
  endtask

  task automatic modelEdge(input bit v, input logic [63:0] g);
    bit acc, sw;
    acc        = v && !mPendFull;
    sw         = 1'b0;
    mFrameDone = 1'b0;
    mPop       = $countones(mDisplay);
    if (!mScanning) begin
      if (mPendFull) begin
        mScanning = 1'b1;
        mT        = 0;
        sw        = 1'b1;
      end
    end else begin
      mT++;
      if (mT % FRAME == 0) begin
        mFrameDone = 1'b1;
        if (mPendFull) sw = 1'b1;
      end
    end
    if (sw) begin
      mDisplay  = mPending;
      mPendFull = 1'b0;
    end
    if (acc) begin
      mPending  = g;
      mPendFull = 1'b1;
    end
    lastAccept = acc;
  endtask

  task automatic checkOne(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic [7:0] eRow, eCol;
    int r;
    eRow = '0;
    eCol = '0;
    if (mScanning && (mT % ROWT) < DWELL) begin
      r    = (mT / ROWT) % 8;
      eRow = 8'd1 << r;
      eCol = mDisplay[r*8 +: 8];
    end
    checkOne("row_sel",    64'(row_sel),    64'(eRow ^ INV));
    checkOne("col_data",   64'(col_data),   64'(eCol ^ INV));
    checkOne("frame_done", 64'(frame_done), 64'(mFrameDone));
    checkOne("population", 64'(population), 64'(mPop));
    checkOne("grid_ready", 64'(grid_ready), 64'(!mPendFull));
  endtask

  task automatic applyStimulus(input bit v, input logic [63:0] g);
    grid_valid = v;
    grid_in    = g;
    @(posedge clk);
    modelEdge(v, g);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [63:0] g3, offer;
    bit offering;
    int n;

    modelReset();
    #3;
    checkOutput();
    #10 reset = 1'b1;

    // Idle with no traffic.
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0);

    // Corner-cell pattern, then the full grid offered mid-frame.
    applyStimulus(1'b1, 64'h8000_0000_0000_0001);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0);
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

    // Third grid must wait for the frame-end swap.
    g3 = {$urandom, $urandom};
    lastAccept = 1'b0;
    n = 0;
    while (!lastAccept && n < 200) begin
      applyStimulus(1'b1, g3);
      n++;
    end
    vectors++;
    assert (lastAccept) else begin
      miscompares++;
      $error("[TB] FAIL third_grid_accept observed=%0d expected=1", lastAccept);
    end

    // Three frames with nothing new.
    for (int i = 0; i < 3 * FRAME + 45; i++) applyStimulus(1'b0, '0);

    // Random traffic, holding each offer until it is taken.
    offering = 1'b0;
    offer    = '0;
    for (int i = 0; i < 400; i++) begin
      if (!offering && $urandom_range(0, 2) == 0) begin
        offering = 1'b1;
        case ($urandom_range(0, 3))
          0:       offer = '0;
          1:       offer = '1;
          default: offer = {$urandom, $urandom};
        endcase
      end
      applyStimulus(offering, offer);
      if (lastAccept) offering = 1'b0;
    end

    // Reset in the middle of row 3.
    n = 0;
    while (!(mScanning && (mT % FRAME) / ROWT == 3 && (mT % ROWT) == 1) && n < 200) begin
      applyStimulus(1'b0, '0);
      n++;
    end
    vectors++;
    assert (n < 200) else begin
      miscompares++;
      $error("[TB] FAIL reach_row3 observed=timeout expected=row3");
    end
    #2 reset = 1'b0;
    modelReset();
    #1;
    checkOutput();
    #3 reset = 1'b1;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0);

    applyStimulus(1'b1, {$urandom, $urandom});
    for (int i = 0; i < FRAME + 20; i++) applyStimulus(1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
